// File: rtl/fft_stage_pkg.sv
// fft_stage_pkg
// Shared helpers for the pipelined FFT stage:
//   clog2            - ceiling log2 for elaboration-time widths
//   ow_calc          - output part width (NBITS + 1 + NBITSCOEFF)
//   tw_re_q/tw_im_q  - quantised twiddle parts, evaluated at elaboration
//   c_pack/c_re/c_im - complex {re, im} word packing and sign-extending unpack
// No ports (package).
package fft_stage_pkg;

  localparam real PI = 3.14159265358979323846;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int ow_calc(input int nbits, input int nbc);
    return nbits + 1 + nbc;
  endfunction

  // Power series keeps the table independent of tool support for $cos/$sin
  // in constant functions; the angle never exceeds pi, so 30 terms is ample.
  function automatic real series_cos(input real x);
    real term;
    real sum;
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i < 30; i++) begin
      term = -term * x * x / (real'(2 * i - 1) * real'(2 * i));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real series_sin(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int i = 1; i < 30; i++) begin
      term = -term * x * x / (real'(2 * i) * real'(2 * i + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Round half away from zero; $rtoi truncates toward zero.
  function automatic int round_haz(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  function automatic int tw_re_q(input int k, input int n, input int nbc);
    real scale;
    real ang;
    scale = real'(1 << (nbc - 2));
    ang   = 2.0 * PI * real'(k) / real'(n);
    return round_haz(scale * series_cos(ang));
  endfunction

  // Forward transform twiddle: imaginary part is -sin.
  function automatic int tw_im_q(input int k, input int n, input int nbc);
    real scale;
    real ang;
    scale = real'(1 << (nbc - 2));
    ang   = 2.0 * PI * real'(k) / real'(n);
    return -round_haz(scale * series_sin(ang));
  endfunction

  function automatic logic [63:0] c_pack(input logic signed [31:0] re,
                                         input logic signed [31:0] im,
                                         input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return ((64'(re) & m) << w) | (64'(im) & m);
  endfunction

  function automatic logic signed [31:0] c_re(input logic [63:0] word, input int w);
    logic [63:0] t;
    t = word >> w;
    return $signed(t[31:0] << (32 - w)) >>> (32 - w);
  endfunction

  function automatic logic signed [31:0] c_im(input logic [63:0] word, input int w);
    return $signed(word[31:0] << (32 - w)) >>> (32 - w);
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// fft_twiddle_rom
// Combinational twiddle table. For beat counter value cnt, lane l receives
// W_k with k = cnt*LANES + l, packed {re, im} of NBITSCOEFF bits each.
// Ports:
//   cnt  in   beat counter
//   tw   out  LANES packed twiddles, lane l at [(l+1)*2*NBITSCOEFF-1 : l*2*NBITSCOEFF]
module fft_twiddle_rom
  import fft_stage_pkg::*;
#(
  parameter int NBITSCOEFF = 11,
  parameter int N          = 128,
  parameter int LANES      = 2,
  localparam int DEPTH     = N / (2 * LANES),
  localparam int CW        = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic [CW-1:0]                 cnt,
  output logic [LANES*2*NBITSCOEFF-1:0] tw
);

  localparam int HALF = N / 2;
  localparam int KW   = (HALF > 1) ? clog2(HALF) : 1;

  logic [2*NBITSCOEFF-1:0] tab [HALF];

  for (genvar i = 0; i < HALF; i++) begin : g_tab
    localparam int RE = tw_re_q(i, N, NBITSCOEFF);
    localparam int IM = tw_im_q(i, N, NBITSCOEFF);
    assign tab[i] = {NBITSCOEFF'(RE), NBITSCOEFF'(IM)};
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [KW-1:0] k;
    assign k = KW'(int'(cnt) * LANES + l);
    assign tw[l*2*NBITSCOEFF +: 2*NBITSCOEFF] = tab[k];
  end

endmodule

// File: rtl/fft_stage_pipe.sv
// fft_stage_pipe
// Two-stage pipelined radix-2 FFT stage with LANES parallel butterflies.
// S1 forms up+down / up-down and latches the lane twiddles; S2 sign-extends
// the sums and multiplies the differences by the twiddle. Full valid/ready
// backpressure: both stages move together when S2 is empty or drained.
// Optional build macro FFT_STAGE_TW_BYPASS_EN adds tw_bypass (unity twiddle).
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, in_up/in_down   LANES packed {re, im} NBITS-bit words
//   out_valid/out_ready, out_up/out_down LANES packed {re, im} OW-bit words
//   out_first                          beat taken at counter value 0
//   tw_bypass (macro only)             force W = 1.0 for this beat
module fft_stage_pipe
  import fft_stage_pkg::*;
#(
  parameter int NBITS      = 10,
  parameter int NBITSCOEFF = NBITS + 1,
  parameter int N          = 128,
  parameter int LANES      = 2,
  localparam int OW        = ow_calc(NBITS, NBITSCOEFF)
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef FFT_STAGE_TW_BYPASS_EN
  input  logic                    tw_bypass,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*2*NBITS-1:0] in_up,
  input  logic [LANES*2*NBITS-1:0] in_down,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*2*OW-1:0]   out_up,
  output logic [LANES*2*OW-1:0]   out_down,
  output logic                    out_first
);

  localparam int DEPTH = N / (2 * LANES);
  localparam int CW    = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int BW    = NBITS + 1;
  localparam int TW    = 2 * NBITSCOEFF;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  logic                  en;
  logic                  accept;
  logic [CW-1:0]         cnt;
  logic [LANES*TW-1:0]   tw_tab;
  logic [LANES*TW-1:0]   tw_sel;
  logic [LANES*2*BW-1:0] bu_w, bd_w;
  logic [LANES*2*OW-1:0] up_w, dn_w;

  logic                  s1_valid, s1_first;
  logic [LANES*2*BW-1:0] s1_bu, s1_bd;
  logic [LANES*TW-1:0]   s1_tw;
  logic                  s2_valid, s2_first;
  logic [LANES*2*OW-1:0] s2_up, s2_down;

  assign en        = !s2_valid || out_ready;
  assign in_ready  = en;
  assign accept    = in_valid && en;
  assign out_valid = s2_valid;
  assign out_first = s2_first;
  assign out_up    = s2_up;
  assign out_down  = s2_down;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  fft_twiddle_rom #(
    .NBITSCOEFF(NBITSCOEFF),
    .N         (N),
    .LANES     (LANES)
  ) u_rom (
    .cnt(cnt),
    .tw (tw_tab)
  );

`ifdef FFT_STAGE_TW_BYPASS_EN
  localparam logic [TW-1:0] UNITY = {NBITSCOEFF'(1 << (NBITSCOEFF - 2)), NBITSCOEFF'(0)};
  assign tw_sel = tw_bypass ? {LANES{UNITY}} : tw_tab;
`else
  assign tw_sel = tw_tab;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [31:0] ur, ui, dr, di;
    logic signed [31:0] ar, ai, br, bi, c, d;

    assign ur = c_re(64'(in_up[l*2*NBITS +: 2*NBITS]), NBITS);
    assign ui = c_im(64'(in_up[l*2*NBITS +: 2*NBITS]), NBITS);
    assign dr = c_re(64'(in_down[l*2*NBITS +: 2*NBITS]), NBITS);
    assign di = c_im(64'(in_down[l*2*NBITS +: 2*NBITS]), NBITS);
    assign bu_w[l*2*BW +: 2*BW] = {BW'(ur + dr), BW'(ui + di)};
    assign bd_w[l*2*BW +: 2*BW] = {BW'(ur - dr), BW'(ui - di)};

    assign ar = c_re(64'(s1_bu[l*2*BW +: 2*BW]), BW);
    assign ai = c_im(64'(s1_bu[l*2*BW +: 2*BW]), BW);
    assign br = c_re(64'(s1_bd[l*2*BW +: 2*BW]), BW);
    assign bi = c_im(64'(s1_bd[l*2*BW +: 2*BW]), BW);
    assign c  = c_re(64'(s1_tw[l*TW +: TW]), NBITSCOEFF);
    assign d  = c_im(64'(s1_tw[l*TW +: TW]), NBITSCOEFF);

    // Operand magnitudes bound the products well inside OW bits, so the
    // packed result is exact without saturation.
    assign up_w[l*2*OW +: 2*OW] = (2*OW)'(c_pack(ar, ai, OW));
    assign dn_w[l*2*OW +: 2*OW] = (2*OW)'(c_pack(br * c - bi * d, br * d + bi * c, OW));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_bu    <= '0;
      s1_bd    <= '0;
      s1_tw    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_first <= in_valid && (cnt == '0);
      s1_bu    <= bu_w;
      s1_bd    <= bd_w;
      s1_tw    <= tw_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_up    <= '0;
      s2_down  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_up    <= up_w;
      s2_down  <= dn_w;
    end
  end

endmodule

// File: tb/tb_fft_stage_pipe.sv
// tb_fft_stage_pipe
// Directed + randomized bench for fft_stage_pipe with a scoreboard model.
module tb_fft_stage_pipe;

  localparam int NBITS      = 10;
  localparam int NBITSCOEFF = 11;
  localparam int N          = 128;
  localparam int LANES      = 2;
  localparam int OW         = NBITS + 1 + NBITSCOEFF;
  localparam int UPW        = LANES * 2 * OW;
  localparam int INW        = LANES * 2 * NBITS;
  localparam int DEPTH      = N / (2 * LANES);
  localparam real PI        = 3.14159265358979323846;
  localparam real SCALE     = 512.0;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, out_first;
  logic [INW-1:0] in_up, in_down;
  logic [UPW-1:0] out_up, out_down;
`ifdef FFT_STAGE_TW_BYPASS_EN
  logic tw_bypass;
`endif

  always #5 clk = ~clk;

  fft_stage_pipe #(
    .NBITS(NBITS), .NBITSCOEFF(NBITSCOEFF), .N(N), .LANES(LANES)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef FFT_STAGE_TW_BYPASS_EN
    .tw_bypass(tw_bypass),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_up(in_up),
    .in_down(in_down),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_up(out_up),
    .out_down(out_down),
    .out_first(out_first)
  );

  typedef struct {
    logic [UPW-1:0] up;
    logic [UPW-1:0] dn;
    logic           first;
  } beat_t;

  beat_t q[$];
  int ur[LANES], ui[LANES], dr[LANES], di[LANES];
  int mcnt, ntotal, npass, nfirst;
  logic byp, last_first;
  logic [UPW-1:0] hu, hd;
  logic [2*OW-1:0] e;

  function automatic int rnd_haz(input real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    else          return -int'($floor(-x + 0.5));
  endfunction

  function automatic int wre(input int k);
    return rnd_haz(SCALE * $cos(2.0 * PI * real'(k) / real'(N)));
  endfunction

  function automatic int wim(input int k);
    return -rnd_haz(SCALE * $sin(2.0 * PI * real'(k) / real'(N)));
  endfunction

  // Expected output of the beat currently presented, at model counter mcnt.
  function automatic beat_t model();
    beat_t b;
    int k, c, d, ar, ai, br, bi;
    b.up = '0;
    b.dn = '0;
    for (int l = 0; l < LANES; l++) begin
      k  = mcnt * LANES + l;
      c  = byp ? 512 : wre(k);
      d  = byp ? 0 : wim(k);
      ar = ur[l] + dr[l];
      ai = ui[l] + di[l];
      br = ur[l] - dr[l];
      bi = ui[l] - di[l];
      b.up[l*2*OW +: 2*OW] = {OW'(ar), OW'(ai)};
      b.dn[l*2*OW +: 2*OW] = {OW'(br * c - bi * d), OW'(br * d + bi * c)};
    end
    b.first = (mcnt == 0);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int l = 0; l < LANES; l++) begin
      in_up[l*2*NBITS +: 2*NBITS]   = {NBITS'(ur[l]), NBITS'(ui[l])};
      in_down[l*2*NBITS +: 2*NBITS] = {NBITS'(dr[l]), NBITS'(di[l])};
    end
`ifdef FFT_STAGE_TW_BYPASS_EN
    tw_bypass = byp;
`endif
  endtask

  task automatic rand_beat();
    for (int l = 0; l < LANES; l++) begin
      ur[l] = int'($urandom_range(0, 1023)) - 512;
      ui[l] = int'($urandom_range(0, 1023)) - 512;
      dr[l] = int'($urandom_range(0, 1023)) - 512;
      di[l] = int'($urandom_range(0, 1023)) - 512;
    end
    drive();
  endtask

  task automatic dir_beat();
    rand_beat();
    ur[0] = 3; ui[0] = 1; dr[0] = 1; di[0] = -2;
    drive();
  endtask

  // Sample handshakes away from the edge, then advance one clock.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    if (out_valid && out_ready) begin
      chk("out_expected", 128'(q.size() != 0), 128'(1));
      if (q.size() != 0) begin
        b = q.pop_front();
        chk("out_up", 128'(out_up), 128'(b.up));
        chk("out_down", 128'(out_down), 128'(b.dn));
        chk("out_first", 128'(out_first), 128'(b.first));
        if (out_first) nfirst++;
        last_first = out_first;
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model());
      mcnt = (mcnt + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      rand_beat();
      tick();
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("drain_empty", 128'(q.size()), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ntotal = 0; npass = 0; nfirst = 0; mcnt = 0;
    byp = 1'b0; last_first = 1'b0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_up = '0; in_down = '0;
`ifdef FFT_STAGE_TW_BYPASS_EN
    tw_bypass = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_first", 128'(out_first), 128'(0));
    chk("rst_out_up", 128'(out_up), 128'(0));
    chk("rst_out_down", 128'(out_down), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // first beat, cnt = 0: latency and directed arithmetic
    dir_beat();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_1cycle_valid", 128'(out_valid), 128'(0));
    tick();
    chk("lat_2cycle_valid", 128'(out_valid), 128'(1));
    e = {OW'(4), OW'(-1)};
    chk("first_up_lane0", 128'(out_up[2*OW-1:0]), 128'(e));
    e = {OW'(1024), OW'(1536)};
    chk("first_down_lane0", 128'(out_down[2*OW-1:0]), 128'(e));
    chk("first_flag", 128'(out_first), 128'(1));
    tick();

    // mid-frame twiddle at cnt = 16 (lane0 k = 32, W = -j)
    send(15);
    dir_beat();
    tick();
    in_valid = 1'b0;
    tick();
    e = {OW'(1536), OW'(-1024)};
    chk("mid_down_lane0", 128'(out_down[2*OW-1:0]), 128'(e));
    drain();

    // counter wrap over two frames
    nfirst = 0;
    send((DEPTH - mcnt) % DEPTH);
    send(64);
    drain();
    chk("wrap_first_count", 128'(nfirst), 128'(2));

    // backpressure with continuous in_valid
    send(4);
    out_ready = 1'b0;
    hu = out_up;
    hd = out_down;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", 128'(in_ready), 128'(0));
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_out_up", 128'(out_up), 128'(hu));
      chk("stall_out_down", 128'(out_down), 128'(hd));
    end
    out_ready = 1'b1;
    send(6);
    drain();

    // random valid/ready traffic
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rand_beat();
      tick();
    end
    drain();

    // mid-frame reset at cnt = 10 with a full pipe
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH && mcnt != 10; i++) begin
      rand_beat();
      tick();
    end
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_first", 128'(out_first), 128'(0));
    q.delete();
    mcnt = 0;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    send(1);
    drain();
    chk("midrst_restart_first", 128'(last_first), 128'(1));

`ifdef FFT_STAGE_TW_BYPASS_EN
    // unity twiddle bypass at cnt = 16
    send((16 - mcnt + DEPTH) % DEPTH);
    byp = 1'b1;
    dir_beat();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    byp = 1'b0;
    drive();
    tick();
    e = {OW'(1024), OW'(1536)};
    chk("bypass_down_lane0", 128'(out_down[2*OW-1:0]), 128'(e));
    drain();
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/fft_stage_pipe.md
Name: fft_stage_pipe

Overview:
- Parametrised, pipelined successor of the parallel FFT stage.
- LANES radix-2 butterflies operate in parallel, followed by a twiddle multiply on each down branch; each up branch is sign-extended.
- The twiddle index is generated internally from a beat counter, and a valid/ready handshake with full backpressure is added.
- Sits between consecutive FFT stages of the N-point parallel FFT.

Parameters:
- NBITS, 10: bits per real/imag input part.
- NBITSCOEFF, NBITS+1: bits per real/imag twiddle part; 1.0 = 2^(NBITSCOEFF-2).
- N, 128: FFT size (power of 2).
- LANES, 2: parallel butterflies (power of 2, LANES <= N/2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_up  in  LANES*2*NBITS  up samples; lane l at bits [(l+1)*2*NBITS-1 : l*2*NBITS]; each complex word is {re, im}, re upper.
- in_down  in  LANES*2*NBITS  down samples, same packing.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_up  out  LANES*2*OW  sign-extended butterfly sums; OW = NBITS+1+NBITSCOEFF.
- out_down  out  LANES*2*OW  twiddled butterfly differences.
- out_first  out  1  marks the output beat whose counter value was 0 (frame start).

Behaviour:
- Reset (rst=0, async): all pipeline registers, both valid flags, the beat counter and out_first clear to 0. in_ready is combinational and reads 1 during reset. A reset mid-frame discards in-flight beats and restarts the counter at 0.
- Pipeline: two register stages S1 and S2. en = !s2_valid || out_ready. in_ready = en. Both stages advance when en=1. Latency is 2 cycles with no stall; throughput is 1 beat per cycle.
- Accepted beat: in_valid && in_ready.
- S1 (per lane):
  - bu = up + down, bd = up - down, each part NBITS+1 bits, full precision.
  - Latches the twiddle for the lane, the counter==0 flag, and s1_valid = in_valid.
- S2 (per lane):
  - out_up = sign-extend(bu) to OW per part; unscaled, same convention as the existing stage.
  - out_down = bd * W, with (a+jb)(c+jd) = (ac-bd) + j(ad+bc).
  - No overflow is possible: |parts| <= 2^NBITS and |c|,|d| <= 2^(NBITSCOEFF-2), so the result fits OW bits signed without saturation.
  - s2_valid is driven to out_valid; out_first follows the latched flag.
- Beat counter cnt:
  - Width log2(N/(2*LANES)), or 1 bit if N=2*LANES.
  - Increments on each accepted beat and wraps from N/(2*LANES)-1 to 0.
  - Stalls do not advance it.
- Twiddle for lane l: k = cnt*LANES + l (0..N/2-1). W_k = round(2^(NBITSCOEFF-2)*cos(2πk/N)) - j*round(2^(NBITSCOEFF-2)*sin(2πk/N)), both parts NBITSCOEFF-bit signed. Rounding is half away from zero, evaluated at elaboration.
- Stall: while out_valid && !out_ready, every register holds, outputs are stable and in_ready=0.
- Bubbles: in_valid=0 with en=1 inserts a bubble; the counter holds.
- Simultaneous out_ready and in_valid on a full pipe: accept and shift in the same cycle, with no gap and no loss.

Optional Feature:
- Macro: FFT_STAGE_TW_BYPASS_EN.
- Defined: adds input port tw_bypass (1 bit, sampled with the beat at S1). When 1, every lane uses W = (2^(NBITSCOEFF-2), 0) and the counter still advances.
- Undefined: the port is absent and the twiddle always comes from the table.

Decomposition:
- Package fft_stage_pkg holds:
  - constant function clog2;
  - twiddle-quantisation constant functions (cos/sin scaled, rounded);
  - OW derivation;
  - complex pack/unpack helper functions.
- Sub-module fft_twiddle_rom(NBITSCOEFF, N, LANES): combinational table indexed by cnt, outputting LANES twiddles. The twiddles are registered in S1 by the parent.

Test Plan:
- Reset value check: hold rst=0 -> out_valid=0, out_first=0, out_up=out_down=0, in_ready=1. Release rst, then send 1 beat -> out_valid rises exactly 2 cycles after acceptance.
- First-beat arithmetic (defaults, cnt=0): lane0 up=(3,1), down=(1,-2) -> out_up lane0=(4,-1), out_down lane0 = (2,3)*(512,0) = (1024,1536), out_first=1.
- Mid-frame twiddle (cnt=16): lane0 k=32, W=(0,-512); up=(3,1), down=(1,-2) -> out_down lane0=(1536,-1024). Lane1 k=33 is compared against the reference model.
- Counter wrap: 64 back-to-back beats -> out_first high on beats 0 and 32 only; beat 32 again uses k=0 for lane0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 continuous -> out data constant, in_ready=0, no beat lost or duplicated, and the output sequence matches the model after release.
- Mid-frame reset and optional feature:
  - Assert rst at cnt=10 -> valids drop immediately; after release the first beat has out_first=1.
  - With FFT_STAGE_TW_BYPASS_EN and tw_bypass=1 at cnt=16 -> out_down = bd*512 + j0 scaling.
